// File: rtl/eth_pkg.sv
// Shared ethernet receive definitions: ethertype and MAC constants,
// header field types, dispatcher FSM states and a select-width helper.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

    typedef logic [47:0] mac_t;
    typedef logic [15:0] ethertype_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_rx_classify.sv
// Combinational packet classifier: destination MAC acceptance and
// ethertype-to-channel lookup (lowest matching table index wins, so a
// duplicated entry at a higher index is never selected).
module eth_rx_classify
    import eth_pkg::*;
#(
    parameter int                         NUM_CHANNELS     = 2,
    parameter int                         SEL_W            = 1,
    parameter logic [NUM_CHANNELS*16-1:0] ETHERTYPES       = {ETHERTYPE_IPV4, ETHERTYPE_ARP},
    parameter logic [47:0]                OUR_MAC          = 48'h0706_0504_0302,
    parameter bit                         ACCEPT_MULTICAST = 1'b1
)(
    input  logic [47:0]      dst_mac_i,
    input  logic [15:0]      ethertype_i,
    output logic             accept_o,
    output logic             match_o,
    output logic [SEL_W-1:0] sel_o
);

    // Unicast, broadcast or (optionally) group address acceptance.
    always_comb begin
        accept_o = (dst_mac_i == OUR_MAC) ||
                   (dst_mac_i == MAC_BROADCAST) ||
                   (ACCEPT_MULTICAST && dst_mac_i[0]);
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        match_o = 1'b0;
        sel_o   = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (ethertype_i == ETHERTYPES[16*i +: 16]) begin
                match_o = 1'b1;
                sel_o   = SEL_W'(i);
            end else begin
                match_o = match_o;
                sel_o   = sel_o;
            end
        end
    end

endmodule

// File: rtl/eth_rx_dispatch.sv
// Receive-side ethernet dispatcher. Decides once per packet (one bubble
// cycle in IDLE) whether to route it to a channel or drop it, then passes
// beats through combinationally until tlast. The decision and src MAC are
// frozen for the whole packet.
// Optional statistics counters are built when ETH_RX_DISPATCH_STATS_EN is defined.
module eth_rx_dispatch
    import eth_pkg::*;
#(
    parameter int                         AXIS_BYTES       = 4,
    parameter int                         NUM_CHANNELS     = 2,
    parameter logic [NUM_CHANNELS*16-1:0] ETHERTYPES       = {ETHERTYPE_IPV4, ETHERTYPE_ARP},
    parameter logic [47:0]                OUR_MAC          = 48'h0706_0504_0302,
    parameter bit                         ACCEPT_MULTICAST = 1'b1
)(
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      axis_i_tvalid,
    output logic                      axis_i_tready,
    input  logic                      axis_i_tlast,
    input  logic [AXIS_BYTES-1:0]     axis_i_tkeep,
    input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
    input  logic [47:0]               axis_i_dst_mac,
    input  logic [47:0]               axis_i_src_mac,
    input  logic [15:0]               axis_i_ethertype,
    output logic [NUM_CHANNELS-1:0]   axis_o_tvalid,
    input  logic [NUM_CHANNELS-1:0]   axis_o_tready,
    output logic                      axis_o_tlast,
    output logic [AXIS_BYTES-1:0]     axis_o_tkeep,
    output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic [47:0]               axis_o_src_mac
`ifdef ETH_RX_DISPATCH_STATS_EN
    ,
    output logic [31:0]               stat_rx_pkts,
    output logic [31:0]               stat_drop_mac_pkts,
    output logic [31:0]               stat_drop_type_pkts,
    output logic [NUM_CHANNELS*32-1:0] stat_chan_pkts
`endif
);

    localparam int SEL_W = sel_width(NUM_CHANNELS);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    mac_t             src_mac_q, src_mac_d;

    logic             cls_accept_s;
    logic             cls_match_s;
    logic [SEL_W-1:0] cls_sel_s;

    eth_rx_classify #(
        .NUM_CHANNELS     (NUM_CHANNELS),
        .SEL_W            (SEL_W),
        .ETHERTYPES       (ETHERTYPES),
        .OUR_MAC          (OUR_MAC),
        .ACCEPT_MULTICAST (ACCEPT_MULTICAST)
    ) u_classify (
        .dst_mac_i   (axis_i_dst_mac),
        .ethertype_i (axis_i_ethertype),
        .accept_o    (cls_accept_s),
        .match_o     (cls_match_s),
        .sel_o       (cls_sel_s)
    );

    // Next-state and handshake steering; only the selected channel ever sees tvalid.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        src_mac_d     = src_mac_q;
        axis_i_tready = 1'b0;
        axis_o_tvalid = '0;
        case (state_q)
            ST_IDLE: begin
                if (axis_i_tvalid) begin
                    src_mac_d = axis_i_src_mac;
                    if (cls_accept_s && cls_match_s) begin
                        state_d = ST_ROUTE;
                        sel_d   = cls_sel_s;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                axis_o_tvalid[sel_q] = axis_i_tvalid;
                axis_i_tready        = axis_o_tready[sel_q];
                if (axis_i_tvalid && axis_o_tready[sel_q] && axis_i_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ROUTE;
                end
            end
            ST_DROP: begin
                axis_i_tready = 1'b1;
                if (axis_i_tvalid && axis_i_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Packet decision state: FSM, selected channel and latched source MAC.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            src_mac_q <= 48'h0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            src_mac_q <= src_mac_d;
        end
    end

    assign axis_o_tlast   = axis_i_tlast;
    assign axis_o_tkeep   = axis_i_tkeep;
    assign axis_o_tdata   = axis_i_tdata;
    assign axis_o_src_mac = src_mac_q;

`ifdef ETH_RX_DISPATCH_STATS_EN
    logic        decide_s;
    logic [31:0] rx_cnt_q;
    logic [31:0] drop_mac_cnt_q;
    logic [31:0] drop_type_cnt_q;
    logic [31:0] chan_cnt_q [NUM_CHANNELS];

    assign decide_s = (state_q == ST_IDLE) && axis_i_tvalid;

    // Per-packet counters, bumped in the IDLE decision cycle; wrap naturally.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rx_cnt_q        <= 32'd0;
            drop_mac_cnt_q  <= 32'd0;
            drop_type_cnt_q <= 32'd0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                chan_cnt_q[i] <= 32'd0;
            end
        end else if (decide_s) begin
            rx_cnt_q <= rx_cnt_q + 32'd1;
            if (!cls_accept_s) begin
                drop_mac_cnt_q <= drop_mac_cnt_q + 32'd1;
            end else if (!cls_match_s) begin
                drop_type_cnt_q <= drop_type_cnt_q + 32'd1;
            end else begin
                chan_cnt_q[cls_sel_s] <= chan_cnt_q[cls_sel_s] + 32'd1;
            end
        end else begin
            rx_cnt_q <= rx_cnt_q;
        end
    end

    assign stat_rx_pkts        = rx_cnt_q;
    assign stat_drop_mac_pkts  = drop_mac_cnt_q;
    assign stat_drop_type_pkts = drop_type_cnt_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan_stat
        assign stat_chan_pkts[32*g +: 32] = chan_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Scoreboard bench for eth_rx_dispatch: the driver pushes each routed beat's
// expected channel/data/src MAC into a queue; a negedge monitor pops and
// compares on every output handshake.
module tb_eth_rx_dispatch;

    logic         clk;
    logic         aresetn;
    logic         axis_i_tvalid;
    logic         axis_i_tready;
    logic         axis_i_tlast;
    logic [3:0]   axis_i_tkeep;
    logic [31:0]  axis_i_tdata;
    logic [47:0]  axis_i_dst_mac;
    logic [47:0]  axis_i_src_mac;
    logic [15:0]  axis_i_ethertype;
    logic [1:0]   axis_o_tvalid;
    logic [1:0]   axis_o_tready;
    logic         axis_o_tlast;
    logic [3:0]   axis_o_tkeep;
    logic [31:0]  axis_o_tdata;
    logic [47:0]  axis_o_src_mac;
`ifdef ETH_RX_DISPATCH_STATS_EN
    logic [31:0]  stat_rx_pkts;
    logic [31:0]  stat_drop_mac_pkts;
    logic [31:0]  stat_drop_type_pkts;
    logic [63:0]  stat_chan_pkts;
`endif

    eth_rx_dispatch dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .axis_i_tvalid    (axis_i_tvalid),
        .axis_i_tready    (axis_i_tready),
        .axis_i_tlast     (axis_i_tlast),
        .axis_i_tkeep     (axis_i_tkeep),
        .axis_i_tdata     (axis_i_tdata),
        .axis_i_dst_mac   (axis_i_dst_mac),
        .axis_i_src_mac   (axis_i_src_mac),
        .axis_i_ethertype (axis_i_ethertype),
        .axis_o_tvalid    (axis_o_tvalid),
        .axis_o_tready    (axis_o_tready),
        .axis_o_tlast     (axis_o_tlast),
        .axis_o_tkeep     (axis_o_tkeep),
        .axis_o_tdata     (axis_o_tdata),
        .axis_o_src_mac   (axis_o_src_mac)
`ifdef ETH_RX_DISPATCH_STATS_EN
        ,
        .stat_rx_pkts        (stat_rx_pkts),
        .stat_drop_mac_pkts  (stat_drop_mac_pkts),
        .stat_drop_type_pkts (stat_drop_type_pkts),
        .stat_chan_pkts      (stat_chan_pkts)
`endif
    );

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [47:0] src;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pkt_id = 0;
    bit   toggle_en = 1'b0;

    // MAC values carry the first octet in bits [7:0], so bit 0 is the group bit.
    localparam logic [47:0] MAC_OURS  = 48'h0706_0504_0302;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC_OTHER = 48'h0100_0000_0002; // 02:00:00:00:00:01
    localparam logic [47:0] MAC_MCAST = 48'h0100_5E00_0001; // group bit set

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int p, input int b);
        return {8'(p), 8'(b), 8'hC3, 8'(b * 7)};
    endfunction

    // Drive one packet; exp_ch < 0 means it must be dropped. abort_at >= 0
    // pulses aresetn while that beat is being presented.
    task automatic send_pkt(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input int nb, input logic [3:0] lk,
                            input int exp_ch, input bit chk_cyc, input bit mangle,
                            input int abort_at);
        int cyc;
        int guard;
        bit done;
        exp_t e;
        cyc = 0;
        pkt_id++;
        axis_i_dst_mac   = dst;
        axis_i_src_mac   = src;
        axis_i_ethertype = et;
        for (int b = 0; b < nb; b++) begin
            if (mangle && b == 1) begin
                axis_i_dst_mac   = 48'h0E0E_0D0C_0B0A;
                axis_i_src_mac   = 48'h1010_1010_1010;
                axis_i_ethertype = 16'h86DD;
            end
            axis_i_tdata  = beat_data(pkt_id, b);
            axis_i_tkeep  = (b == nb - 1) ? lk : 4'hF;
            axis_i_tlast  = (b == nb - 1);
            axis_i_tvalid = 1'b1;
            if (b == abort_at) begin
                #2;
                aresetn = 1'b0;
                #1;
                chk("rst_o_tvalid", 64'(axis_o_tvalid), 64'd0);
                chk("rst_i_tready", 64'(axis_i_tready), 64'd0);
                chk("rst_src_mac", 64'(axis_o_src_mac), 64'd0);
`ifdef ETH_RX_DISPATCH_STATS_EN
                chk("rst_stat_rx", 64'(stat_rx_pkts), 64'd0);
                chk("rst_stat_chan", 64'(stat_chan_pkts), 64'd0);
`endif
                axis_i_tvalid = 1'b0;
                axis_i_tlast  = 1'b0;
                @(posedge clk);
                #1;
                aresetn = 1'b1;
                return;
            end
            if (exp_ch >= 0) begin
                e.ch   = 3'(exp_ch);
                e.data = axis_i_tdata;
                e.keep = axis_i_tkeep;
                e.last = axis_i_tlast;
                e.src  = src;
                q.push_back(e);
            end
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                @(negedge clk);
                cyc++;
                if (b == 0 && cyc == 1) begin
                    chk("bubble_tready", 64'(axis_i_tready), 64'd0);
                end else if (axis_i_tready) begin
                    done = 1'b1;
                end
                guard++;
                if (!done && guard > 64) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout: beat %0d of packet %0d got no handshake expected accept", b, pkt_id);
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
        if (chk_cyc) chk("pkt_cycles", 64'(cyc), 64'(nb + 1));
    endtask

    // Output monitor: one-hot valid, ready steering, and in-order delivery.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (aresetn && axis_o_tvalid != 2'b00) begin
                chk("onehot", 64'($countones(axis_o_tvalid)), 64'd1);
                chk("in_ready_steer", 64'(axis_i_tready), 64'(|(axis_o_tvalid & axis_o_tready)));
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got tvalid=%b expected none", axis_o_tvalid);
                end else begin
                    e = q[0];
                    chk("channel", 64'(axis_o_tvalid), 64'd1 << e.ch);
                    if ((axis_o_tvalid & axis_o_tready) != 2'b00) begin
                        void'(q.pop_front());
                        chk("tdata", 64'(axis_o_tdata), 64'(e.data));
                        chk("tkeep", 64'(axis_o_tkeep), 64'(e.keep));
                        chk("tlast", 64'(axis_o_tlast), 64'(e.last));
                        chk("src_mac", 64'(axis_o_src_mac), 64'(e.src));
                    end
                end
            end
        end
    end

    // Channel 1 back-pressure pattern: toggles every cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) axis_o_tready[1] = ~axis_o_tready[1];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        aresetn          = 1'b0;
        axis_i_tvalid    = 1'b0;
        axis_i_tlast     = 1'b0;
        axis_i_tkeep     = 4'h0;
        axis_i_tdata     = 32'h0;
        axis_i_dst_mac   = 48'h0;
        axis_i_src_mac   = 48'h0;
        axis_i_ethertype = 16'h0;
        axis_o_tready    = 2'b11;
        #1;
        chk("reset_o_tvalid", 64'(axis_o_tvalid), 64'd0);
        chk("reset_i_tready", 64'(axis_i_tready), 64'd0);
        chk("reset_src_mac", 64'(axis_o_src_mac), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // 1: ARP broadcast, 11 beats, last keep 0011 -> channel 0
        send_pkt(MAC_BCAST, 48'hA1A2_A3A4_A5A6, 16'h0806, 11, 4'b0011, 0, 1'b1, 1'b0, -1);

        // 2: IPv4 unicast under toggling ready on channel 1, sideband changed mid-packet
        axis_o_tready = 2'b01;
        toggle_en     = 1'b1;
        send_pkt(MAC_OURS, 48'hB1B2_B3B4_B5B6, 16'h0800, 6, 4'b1111, 1, 1'b0, 1'b1, -1);
        toggle_en = 1'b0;
        @(posedge clk);
        #1;
        axis_o_tready = 2'b11;

        // 3: unicast to a foreign MAC -> dropped, tready held high
        send_pkt(MAC_OTHER, 48'hC1C2_C3C4_C5C6, 16'h0806, 5, 4'b1111, -1, 1'b1, 1'b0, -1);
`ifdef ETH_RX_DISPATCH_STATS_EN
        chk("stat_drop_mac", 64'(stat_drop_mac_pkts), 64'd1);
`endif

        // 4: broadcast IPv6 -> type drop, then back-to-back ARP routed after one bubble
        send_pkt(MAC_BCAST, 48'hD1D2_D3D4_D5D6, 16'h86DD, 4, 4'b0111, -1, 1'b1, 1'b0, -1);
        send_pkt(MAC_BCAST, 48'hE1E2_E3E4_E5E6, 16'h0806, 3, 4'b0001, 0, 1'b1, 1'b0, -1);
`ifdef ETH_RX_DISPATCH_STATS_EN
        chk("stat_drop_type", 64'(stat_drop_type_pkts), 64'd1);
`endif

        // Group-addressed ARP accepted through the multicast rule
        send_pkt(MAC_MCAST, 48'hF1F2_F3F4_F5F6, 16'h0806, 2, 4'b1111, 0, 1'b1, 1'b0, -1);

        // 5: single-beat packets back to back, channel 0 then channel 1
        send_pkt(MAC_BCAST, 48'h0102_0304_0506, 16'h0806, 1, 4'b1111, 0, 1'b1, 1'b0, -1);
        send_pkt(MAC_OURS,  48'h0708_090A_0B0C, 16'h0800, 1, 4'b0011, 1, 1'b1, 1'b0, -1);
`ifdef ETH_RX_DISPATCH_STATS_EN
        chk("stat_rx", 64'(stat_rx_pkts), 64'd8);
        chk("stat_chan", 64'(stat_chan_pkts), {32'd2, 32'd4});
`endif

        // 6: reset pulsed while beat 5 of a routed packet is presented
        send_pkt(MAC_OURS, 48'h2122_2324_2526, 16'h0800, 8, 4'b1111, 1, 1'b0, 1'b0, 5);
        chk("queue_after_reset", 64'(q.size()), 64'd0);
        send_pkt(MAC_BCAST, 48'h3132_3334_3536, 16'h0806, 2, 4'b0011, 0, 1'b1, 1'b0, -1);

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
